fft_stage_pairer: RTL and testbench

Radix-2 DIF stage front end for the streaming FFT. It takes the in-order complex sample stream and buffers the first half of every 2·span block. It then pairs each buffered sample x1 with its partner x2 from the second half, and drives the twiddle provider's enable so the twiddle word lands on the same cycle as the pair. Its outputs feed the butterfly / complex-multiply unit directly.

---
 rtl/fft_stage_pairer.sv | 129 ++++++++++++
 tb/tb_fft_stage_pairer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_pairer.sv
// fft_stage_pairer: radix-2 DIF stage front end for the streaming FFT.
// The first half of every 2*span block is buffered in a synchronous-read RAM.
// Each second-half sample is then paired with its buffered partner, and the
// twiddle word requested through tf_en is aligned with that pair.
// Optional build macro: FFT_PAIRER_TF_CHECK_EN enables the sticky twiddle
// alignment check on tf_valid. Without it, tf_err is tied low.
module fft_stage_pairer #(
  parameter int unsigned float_len     = 32,
  parameter int unsigned bram_addr_len = 13,
  parameter int unsigned stageNum      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*float_len-1:0]   din,
  input  logic                     din_valid,
  output logic                     tf_en,
  input  logic [2*float_len-1:0]   tf_data,
  input  logic                     tf_valid,
  output logic [2*float_len-1:0]   x1_out,
  output logic [2*float_len-1:0]   x2_out,
  output logic [2*float_len-1:0]   tf_out,
  output logic                     pair_valid,
  output logic                     block_last,
  output logic                     tf_err
);

  localparam int unsigned DATA_W = 2 * float_len;
  localparam int unsigned SPAN_W = bram_addr_len - stageNum;
  localparam int unsigned SPAN   = 1 << SPAN_W;
  localparam int unsigned CNT_W  = SPAN_W + 1;
  // A span of 1 still needs a 1-bit RAM address; its value is always 0
  localparam int unsigned IDX_W  = (SPAN_W == 0) ? 1 : SPAN_W;

  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_phase_b;
  logic              w_wr_en;
  logic              w_rd_en;

  logic [DATA_W-1:0] r_mem [SPAN];
  logic [DATA_W-1:0] r_rd_data;

  logic              r_p_valid;
  logic              r_p_last;
  logic [DATA_W-1:0] r_x2;

  // Phase is the counter MSB; the low bits address the half-block buffer
  assign w_idx     = IDX_W'(r_cnt % CNT_W'(SPAN));
  assign w_phase_b = r_cnt[CNT_W-1];
  assign w_wr_en   = din_valid & ~w_phase_b;
  assign w_rd_en   = din_valid &  w_phase_b;

  // One twiddle request per second-half sample, in stream order
  assign tf_en = w_rd_en;

  // Half-block buffer: write in phase A, synchronous read in phase B
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= din;
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[w_idx];
    end
  end

  // Accepted-sample counter; wraps naturally from 2*span-1 to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (din_valid) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Pair-forming stage: capture x2 and mark the pair in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_valid <= 1'b0;
      r_p_last  <= 1'b0;
      r_x2      <= '0;
    end else begin
      r_p_valid <= w_rd_en;
      if (w_rd_en) begin
        r_x2     <= din;
        r_p_last <= (w_idx == IDX_W'(SPAN - 1));
      end
    end
  end

  // Output stage: RAM read data and twiddle word both land this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_out     <= '0;
      x2_out     <= '0;
      tf_out     <= '0;
      pair_valid <= 1'b0;
      block_last <= 1'b0;
    end else begin
      pair_valid <= r_p_valid;
      block_last <= r_p_valid & r_p_last;
      if (r_p_valid) begin
        x1_out <= r_rd_data;
        x2_out <= r_x2;
        tf_out <= tf_data;
      end
    end
  end

`ifdef FFT_PAIRER_TF_CHECK_EN
  logic r_tf_err;

  // Sticky flag: provider's valid must track the in-flight pair exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tf_err <= 1'b0;
    end else if (r_p_valid != tf_valid) begin
      r_tf_err <= 1'b1;
    end
  end

  assign tf_err = r_tf_err;
`else
  logic w_unused_tf_valid;

  assign w_unused_tf_valid = tf_valid;
  assign tf_err            = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_pairer.sv
// Bench for fft_stage_pairer (span = 4) with a 1-cycle twiddle provider model.
// Reference: per-block arrays of accepted samples produce expected pairs,
// each due two cycles after its second-half sample is accepted.
module tb_fft_stage_pairer;

  localparam int unsigned FL   = 32;
  localparam int unsigned BAL  = 4;
  localparam int unsigned SN   = 2;
  localparam int          SPAN = 1 << (BAL - SN);
  localparam int unsigned DW   = 2 * FL;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          tf_en;
  logic [DW-1:0] tf_data;
  logic          tf_valid;
  logic [DW-1:0] x1_out;
  logic [DW-1:0] x2_out;
  logic [DW-1:0] tf_out;
  logic          pair_valid;
  logic          block_last;
  logic          tf_err;

  fft_stage_pairer #(
    .float_len     (FL),
    .bram_addr_len (BAL),
    .stageNum      (SN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .tf_en      (tf_en),
    .tf_data    (tf_data),
    .tf_valid   (tf_valid),
    .x1_out     (x1_out),
    .x2_out     (x2_out),
    .tf_out     (tf_out),
    .pair_valid (pair_valid),
    .block_last (block_last),
    .tf_err     (tf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] x1;
    logic [DW-1:0] x2;
    logic [DW-1:0] tf;
    logic          last;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] first_half [SPAN];
  int            k_in_blk;
  int            cyc;
  int            n_checks;
  int            n_errors;
  logic          dly_mode;
  logic          err_exp;

  function automatic logic [DW-1:0] tw_word(input int i);
    return {32'(i), 32'hC0DE_0000 | 32'(i)};
  endfunction

  function automatic logic [DW-1:0] mk(input int k);
    return {32'(k), ~32'(k)};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Twiddle provider: 1-cycle latency, word = address counter (mod span);
  // dly_mode adds one extra cycle to both valid and data
  int            tw;
  logic          d_v;
  logic [DW-1:0] d_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tw       <= 0;
      tf_valid <= 1'b0;
      tf_data  <= '0;
      d_v      <= 1'b0;
      d_d      <= '0;
    end else begin
      d_v <= tf_en;
      d_d <= tw_word(tw);
      if (tf_en) tw <= (tw + 1) % SPAN;
      if (dly_mode) begin
        tf_valid <= d_v;
        tf_data  <= d_d;
      end else begin
        tf_valid <= tf_en;
        tf_data  <= tw_word(tw);
      end
    end
  end

  // Reference model: accept samples, form expected pairs
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && din_valid) begin
      if (k_in_blk < SPAN) begin
        first_half[k_in_blk] = din;
      end else begin
        e.x1   = first_half[k_in_blk - SPAN];
        e.x2   = din;
        e.tf   = tw_word(k_in_blk - SPAN);
        e.last = (k_in_blk == 2 * SPAN - 1);
        e.due  = cyc + 1;
        q.push_back(e);
      end
      k_in_blk = (k_in_blk + 1) % (2 * SPAN);
    end
  end

  // Monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic exp_pv;
    if (rst) begin
      check("rst_pair_valid", DW'(pair_valid), '0);
      check("rst_block_last", DW'(block_last), '0);
      check("rst_tf_en", DW'(tf_en), '0);
      check("rst_tf_err", DW'(tf_err), '0);
      check("rst_x1", x1_out, '0);
      check("rst_x2", x2_out, '0);
      check("rst_tf", tf_out, '0);
    end else begin
      check("tf_en", DW'(tf_en), DW'(din_valid && (k_in_blk >= SPAN)));
      exp_pv = (q.size() > 0) && (q[0].due == cyc);
      check("pair_valid", DW'(pair_valid), DW'(exp_pv));
      if (exp_pv) begin
        if (pair_valid) begin
          check("x1_out", x1_out, q[0].x1);
          check("x2_out", x2_out, q[0].x2);
          if (!dly_mode) check("tf_out", tf_out, q[0].tf);
          check("block_last", DW'(block_last), DW'(q[0].last));
        end
        if (dly_mode) err_exp = 1'b1;
        void'(q.pop_front());
      end else begin
        check("block_last_idle", DW'(block_last), '0);
      end
`ifdef FFT_PAIRER_TF_CHECK_EN
      check("tf_err", DW'(tf_err), DW'(err_exp));
`else
      check("tf_err", DW'(tf_err), '0);
`endif
    end
  end

  task automatic drive(input logic [DW-1:0] d, input logic v);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cyc       = 0;
    n_checks  = 0;
    n_errors  = 0;
    k_in_blk  = 0;
    dly_mode  = 1'b0;
    err_exp   = 1'b0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // One block of 8 consecutive samples
    for (int k = 0; k < 8; k++) drive(mk(k), 1'b1);
    idle(4);

    // Same block with a bubble after every sample
    for (int k = 0; k < 8; k++) begin
      drive(mk(k), 1'b1);
      drive({$urandom, $urandom}, 1'b0);
    end
    idle(4);

    // Two blocks back to back
    for (int k = 0; k < 16; k++) drive(mk(k), 1'b1);
    idle(4);

    // Random data with random gaps, four whole blocks
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 2)) drive({$urandom, $urandom}, 1'b0);
      drive({$urandom, $urandom}, 1'b1);
    end
    idle(4);

    // Reset after the sixth sample of a block; in-flight pairs are dropped
    for (int k = 0; k < 6; k++) drive(mk(k), 1'b1);
    rst       = 1'b1;
    din_valid = 1'b0;
    q.delete();
    k_in_blk  = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 20; k < 28; k++) drive(mk(k), 1'b1);
    idle(4);

    // Provider answers one cycle late
    dly_mode = 1'b1;
    for (int k = 0; k < 8; k++) drive(mk(k), 1'b1);
    idle(6);

    check("queue_drained", DW'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
